mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Initiator side of the byte-wide data-memory port: the MEM stage issues one 32-bit load or store, and this block sequences it as four byte transactions.
- Byte order is little-endian: byte k of the word goes to address addr+k, with byte 0 as the LSB.
- While an access is in flight, `ready` is low, which freezes the pipeline.
- Sits between the MEM stage and the byte-addressed data memory, and drives that memory's address, write data and enables.

Parameters:
- BIT_NUMBER, 8: memory byte width; the word is 4*BIT_NUMBER bits.
- MEM_VOL, 2**10: memory words; byte space is 4*MEM_VOL.
- ADDR_W, 12: byte address width, equal to log2(4*MEM_VOL).
- READ_LAT, 1: cycles from mem_re/mem_addr to valid mem_rdata. Legal range 1..3.

Ports:
- clk, in, 1: clock, rising edge.
- rst, in, 1: reset, synchronous, active-high.
- wr_en, in, 1: store request from MEM stage.
- rd_en, in, 1: load request from MEM stage.
- addr, in, 4*BIT_NUMBER: byte address of the word.
- st_val, in, 4*BIT_NUMBER: store data.
- ready, out, 1: high means no access pending, or the access completes this cycle. Low freezes the pipeline.
- rd_data, out, 4*BIT_NUMBER: assembled load result. Held until the next load completes.
- mem_addr, out, ADDR_W: byte address to memory.
- mem_wdata, out, BIT_NUMBER: byte write data.
- mem_we, out, 1: byte write strobe.
- mem_re, out, 1: byte read strobe.
- mem_rdata, in, BIT_NUMBER: byte read data, valid READ_LAT cycles after its mem_re.

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-high.
- Reset values: state=IDLE, cnt=0, rd_data=0, mem_addr=0, mem_wdata=0, mem_we=0, mem_re=0, latched addr/data=0.
- States: IDLE, WRITE, READ, DONE. All memory-side outputs are registered.
- ready is combinational:
  - IDLE: ready = !(rd_en | wr_en).
  - DONE: ready = 1.
  - WRITE, READ: ready = 0.
- IDLE:
  - wr_en=1: latch addr[ADDR_W-1:0] and st_val, go to WRITE. wr_en has priority over rd_en; a simultaneous rd_en is ignored.
  - rd_en=1 (wr_en=0): latch addr, go to READ.
  - Neither: stay in IDLE with no strobes.
- WRITE: cnt = 0..3, one beat per cycle.
  - Each beat: mem_we=1, mem_addr=base+cnt, mem_wdata=byte cnt of the latched data.
  - After beat 3, go to DONE.
  - Request seen in cycle 0 → strobes in cycles 1-4 → DONE/ready in cycle 5.
- READ: cnt = 0 .. 3+READ_LAT.
  - While cnt<4: mem_re=1, mem_addr=base+cnt.
  - While cnt>=READ_LAT: capture mem_rdata into rd_data byte lane (cnt-READ_LAT).
  - After the last capture, go to DONE.
  - With READ_LAT=1: request in cycle 0 → DONE in cycle 6, and rd_data is fully valid in that DONE cycle.
  - rd_data lanes update progressively during READ; the MEM stage samples rd_data only when ready=1.
- DONE: all strobes 0, ready=1. Next state is IDLE; the pipeline advances on this edge.
- Address arithmetic: base+cnt is computed modulo 2^ADDR_W, so a word at the top of memory wraps to byte 0. Upper address bits above ADDR_W are ignored. Unaligned addresses are legal.
- Request stability: requests are held stable by the pipeline while ready=0. Input changes during WRITE/READ are ignored because the latched copies are used.
- Reset mid-operation: immediate return to IDLE with all strobes 0 and rd_data=0. A store that was partially written leaves its written bytes in memory; this is accepted.
- Back-to-back accesses: each access passes through DONE and then IDLE. Minimum spacing is one access per 6 cycles (write) or 6+READ_LAT cycles (read).

Decomposition:
- Shared package holds:
  - State encoding: IDLE=2'd0, WRITE=2'd1, READ=2'd2, DONE=2'd3.
  - BEATS=4.
  - Function for byte-lane select.
- One natural sub-module, byte_gather: a lane-indexed capture register that writes mem_rdata into lane i on a capture strobe and clears on rst.

Test Plan:
1. Store: addr=0x400, st_val=0x00002000 → beats at 0x400..0x403 with wdata 00,20,00,00 and mem_we high in cycles 1-4; ready low in cycles 0-4 and high in cycle 5.
2. Load (model memory preloaded 0x400..0x403 = 00,20,00,00; READ_LAT=1) → rd_data=0x00002000 when ready rises in cycle 6; mem_re high in exactly 4 cycles.
3. rd_en=wr_en=1 together, addr=0x10, st_val=0xC0000000 → write only, no mem_re ever; memory bytes 0x10..0x13 = 00,00,00,C0.
4. Wrap: store 0x11223344 at addr=0xFFE → bytes 0xFFE=44, 0xFFF=33, 0x000=22, 0x001=11.
5. Reset mid-load asserted in cycle 3 → cycle 4 shows IDLE, ready=1 with no request, rd_data=0, strobes 0; a following load of 0x400 returns 0x00002000 correctly.
6. READ_LAT=3 load of the same word → ready rises in cycle 8, rd_data=0x00002000; input addr changed to 0x0 during READ does not alter the beat addresses.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and helpers for the byte-serial data-memory port.
// A word moves as BEATS little-endian byte transactions.
package mem_access_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int BEATS = 4;

  // Bit offset of byte lane 'lane' inside a word built from laneWidth-bit lanes.
  function automatic int laneLsb(input int lane, input int laneWidth);
    return lane * laneWidth;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_byte_gather.sv
// Lane-indexed capture register.
// Assembles a word from bytes returned by the memory one lane at a time.
module byte_gather
  import mem_access_ctrl_pkg::*;
#(
  parameter int BIT_NUMBER = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_capture,
  input  logic [$clog2(BEATS)-1:0]      i_lane,
  input  logic [BIT_NUMBER-1:0]         i_byte,
  output logic [BEATS*BIT_NUMBER-1:0]   o_word
);

  logic [BEATS*BIT_NUMBER-1:0] r_word;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_word <= '0;
    end else if (i_capture) begin
      r_word[laneLsb(int'(i_lane), BIT_NUMBER) +: BIT_NUMBER] <= i_byte;
    end
  end

  assign o_word = r_word;

endmodule

// File: rtl/mem_access_ctrl.sv
// Initiator side of the byte-wide data-memory port.
// Sequences one 32-bit load or store from the MEM stage as four byte beats.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int BIT_NUMBER = 8,
  parameter int MEM_VOL    = 2**10,
  parameter int ADDR_W     = 12,
  parameter int READ_LAT   = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic                      rd_en,
  input  logic [4*BIT_NUMBER-1:0]   addr,
  input  logic [4*BIT_NUMBER-1:0]   st_val,
  output logic                      ready,
  output logic [4*BIT_NUMBER-1:0]   rd_data,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [BIT_NUMBER-1:0]     mem_wdata,
  output logic                      mem_we,
  output logic                      mem_re,
  input  logic [BIT_NUMBER-1:0]     mem_rdata
);

  localparam int WORD_W = BEATS * BIT_NUMBER;
  localparam int CNT_W  = $clog2(BEATS + READ_LAT);
  localparam int LANE_W = $clog2(BEATS);
  localparam logic [ADDR_W-1:0] ADDR_MASK = ADDR_W'(4 * MEM_VOL - 1);
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [CNT_W-1:0]  LAST_RD   = CNT_W'(BEATS - 1 + READ_LAT);
  localparam logic [CNT_W-1:0]  LAT_CNT   = CNT_W'(READ_LAT);

  state_t                r_state;
  state_t                w_nextState;
  logic [CNT_W-1:0]      r_cnt;
  logic [ADDR_W-1:0]     r_base;
  logic [WORD_W-1:0]     r_data;
  logic                  w_issueWe;
  logic                  w_issueRe;
  logic [LANE_W-1:0]     w_beatIdx;
  logic [ADDR_W-1:0]     w_beatBase;
  logic [ADDR_W-1:0]     w_beatAddr;
  logic [WORD_W-1:0]     w_srcWord;
  logic [BIT_NUMBER-1:0] w_beatByte;
  logic                  w_capture;
  logic [LANE_W-1:0]     w_captureLane;
  logic                  w_unusedAddrBits;

  // Bytes above the memory's byte space are deliberately dropped.
  assign w_unusedAddrBits = ^addr[4*BIT_NUMBER-1:ADDR_W];

  // Outputs are registered, so the beat driven next cycle is chosen here;
  // in IDLE the first beat comes straight from the request inputs.
  always_comb begin
    w_nextState = r_state;
    ready       = 1'b0;
    w_issueWe   = 1'b0;
    w_issueRe   = 1'b0;
    w_beatIdx   = '0;
    w_beatBase  = r_base;
    w_srcWord   = r_data;
    case (r_state)
      IDLE: begin
        ready      = !(rd_en || wr_en);
        w_beatBase = addr[ADDR_W-1:0];
        w_srcWord  = st_val;
        if (wr_en) begin
          w_nextState = WRITE;
          w_issueWe   = 1'b1;
        end else if (rd_en) begin
          w_nextState = READ;
          w_issueRe   = 1'b1;
        end
      end
      WRITE: begin
        w_beatIdx = LANE_W'(r_cnt + 1'b1);
        if (r_cnt == LAST_BEAT) begin
          w_nextState = DONE;
        end else begin
          w_issueWe = 1'b1;
        end
      end
      READ: begin
        w_beatIdx = LANE_W'(r_cnt + 1'b1);
        w_issueRe = (r_cnt < LAST_BEAT);
        if (r_cnt == LAST_RD) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        ready       = 1'b1;
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  assign w_beatAddr    = (w_beatBase + ADDR_W'(w_beatIdx)) & ADDR_MASK;
  assign w_beatByte    = w_srcWord[laneLsb(int'(w_beatIdx), BIT_NUMBER) +: BIT_NUMBER];
  assign w_capture     = (r_state == READ) && (r_cnt >= LAT_CNT);
  assign w_captureLane = LANE_W'(r_cnt - LAT_CNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_base    <= '0;
      r_data    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= ((r_state == w_nextState) && ((r_state == WRITE) || (r_state == READ)))
                 ? r_cnt + 1'b1 : '0;
      if ((r_state == IDLE) && (wr_en || rd_en)) begin
        r_base <= addr[ADDR_W-1:0];
        if (wr_en) begin
          r_data <= st_val;
        end
      end
      mem_we <= w_issueWe;
      mem_re <= w_issueRe;
      if (w_issueWe || w_issueRe) begin
        mem_addr <= w_beatAddr;
      end
      if (w_issueWe) begin
        mem_wdata <= w_beatByte;
      end
    end
  end

  byte_gather #(
    .BIT_NUMBER(BIT_NUMBER)
  ) u_gather (
    .clk       (clk),
    .rst       (rst),
    .i_capture (w_capture),
    .i_lane    (w_captureLane),
    .i_byte    (mem_rdata),
    .o_word    (rd_data)
  );

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: two instances (READ_LAT 1 and 3) each
// talk to a behavioural byte memory; expectations come from a word-level model.
module tb_mem_access_ctrl;

  typedef struct packed {
    logic        isWr;
    logic [11:0] addr;
    logic [7:0]  data;
  } beat_t;

  typedef struct packed {
    logic        isLoad;
    logic [7:0]  lat;
    logic [31:0] data;
  } done_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        memInit;
  logic        wrEn [2];
  logic        rdEn [2];
  logic [31:0] addrIn [2];
  logic [31:0] stVal [2];
  logic        ready [2];
  logic [31:0] rdData [2];
  logic [11:0] memAddr [2];
  logic [7:0]  memWdata [2];
  logic        memWe [2];
  logic        memRe [2];
  logic [7:0]  memRdata [2];

  logic [7:0]  devMem [2][4096];
  logic [7:0]  pipe [2][3];
  logic [7:0]  refMem [2][4096];
  logic [31:0] lastLoad [2];
  int          busyCycles [2];

  beat_t beatQ [$];
  done_t doneQ [$];
  beat_t monBeat;
  done_t monDone;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.BIT_NUMBER(8), .MEM_VOL(1024), .ADDR_W(12), .READ_LAT(1)) dutLat1 (
    .clk(clk), .rst(rst), .wr_en(wrEn[0]), .rd_en(rdEn[0]), .addr(addrIn[0]),
    .st_val(stVal[0]), .ready(ready[0]), .rd_data(rdData[0]), .mem_addr(memAddr[0]),
    .mem_wdata(memWdata[0]), .mem_we(memWe[0]), .mem_re(memRe[0]), .mem_rdata(memRdata[0])
  );

  mem_access_ctrl #(.BIT_NUMBER(8), .MEM_VOL(1024), .ADDR_W(12), .READ_LAT(3)) dutLat3 (
    .clk(clk), .rst(rst), .wr_en(wrEn[1]), .rd_en(rdEn[1]), .addr(addrIn[1]),
    .st_val(stVal[1]), .ready(ready[1]), .rd_data(rdData[1]), .mem_addr(memAddr[1]),
    .mem_wdata(memWdata[1]), .mem_we(memWe[1]), .mem_re(memRe[1]), .mem_rdata(memRdata[1])
  );

  function automatic logic [7:0] initByte(input logic [11:0] a);
    return a[7:0] ^ {a[11:8], 4'h9};
  endfunction

  // Byte memory: reads return garbage unless strobed, so mistimed captures show up.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (memInit) begin
        for (int a = 0; a < 4096; a++) devMem[k][a] <= initByte(12'(a));
      end else if (memWe[k]) begin
        devMem[k][memAddr[k]] <= memWdata[k];
      end
      pipe[k][0] <= memRe[k] ? devMem[k][memAddr[k]] : 8'($urandom);
      pipe[k][1] <= pipe[k][0];
      pipe[k][2] <= pipe[k][1];
    end
  end

  assign memRdata[0] = pipe[0][0];
  assign memRdata[1] = pipe[1][2];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Monitor: every strobe pops the beat queue, every completion pops the done queue.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (memWe[k] || memRe[k]) begin
        if (beatQ.size() == 0) begin
          checkOutput("unexpectedStrobe", 32'({memWe[k], memRe[k]}), 32'd0);
        end else begin
          monBeat = beatQ.pop_front();
          checkOutput("beatStrobe", 32'({memWe[k], memRe[k]}), monBeat.isWr ? 32'd2 : 32'd1);
          checkOutput("beatAddr", 32'(memAddr[k]), 32'(monBeat.addr));
          if (monBeat.isWr) checkOutput("beatWdata", 32'(memWdata[k]), 32'(monBeat.data));
        end
      end
      if (wrEn[k] || rdEn[k]) begin
        if (ready[k] === 1'b1) begin
          if (doneQ.size() == 0) begin
            checkOutput("unexpectedDone", 32'(busyCycles[k]), 32'hFFFF_FFFF);
          end else begin
            monDone = doneQ.pop_front();
            checkOutput("latency", 32'(busyCycles[k]), 32'(monDone.lat));
            checkOutput(monDone.isLoad ? "loadData" : "heldRdData", rdData[k], monDone.data);
          end
          busyCycles[k] = 0;
        end else begin
          busyCycles[k]++;
        end
      end else begin
        busyCycles[k] = 0;
      end
    end
  end

  // Caller is at posedge+1; gap adds idle cycles before the request is raised.
  task automatic applyStimulus(input int k, input logic w, input logic r, input logic [31:0] a,
                               input logic [31:0] v, input int gap, input logic scramble);
    logic [11:0] bAddr;
    logic [31:0] expWord;
    done_t d;
    logic got;
    expWord = 32'd0;
    for (int b = 0; b < 4; b++) begin
      bAddr = a[11:0] + 12'(b);
      if (w) begin
        beatQ.push_back('{1'b1, bAddr, v[8*b +: 8]});
        refMem[k][bAddr] = v[8*b +: 8];
      end else begin
        beatQ.push_back('{1'b0, bAddr, 8'h00});
        expWord[8*b +: 8] = refMem[k][bAddr];
      end
    end
    if (w) begin
      d = '{1'b0, 8'd5, lastLoad[k]};
    end else begin
      lastLoad[k] = expWord;
      d = '{1'b1, (k == 0) ? 8'd6 : 8'd8, expWord};
    end
    doneQ.push_back(d);
    repeat (gap) @(posedge clk);
    if (gap > 0) #1;
    wrEn[k] = w;
    rdEn[k] = r;
    addrIn[k] = a;
    stVal[k] = v;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (ready[k] === 1'b1) got = 1'b1;
      else if (scramble && c == 1) begin
        addrIn[k] = 32'd0;
        stVal[k] = $urandom;
      end
    end
    if (!got) begin
      checks++;
      failures++;
      $display("[TB] FAIL readyTimeout: got ready=0 for 20 cycles expected ready=1 (inst %0d)", k);
    end
    @(posedge clk);
    #1;
    wrEn[k] = 1'b0;
    rdEn[k] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected finish before 500000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] lastWrAddr;
    int op;
    rst = 1'b1;
    memInit = 1'b1;
    for (int k = 0; k < 2; k++) begin
      wrEn[k] = 1'b0;
      rdEn[k] = 1'b0;
      addrIn[k] = 32'd0;
      stVal[k] = 32'd0;
      lastLoad[k] = 32'd0;
      busyCycles[k] = 0;
      for (int j = 0; j < 4096; j++) refMem[k][j] = initByte(12'(j));
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    memInit = 1'b0;

    for (int k = 0; k < 2; k++) begin
      checkOutput("resetReady", 32'(ready[k]), 32'd1);
      checkOutput("resetRdData", rdData[k], 32'd0);
      checkOutput("resetMemAddr", 32'(memAddr[k]), 32'd0);
      checkOutput("resetMemWdata", 32'(memWdata[k]), 32'd0);
      checkOutput("resetStrobes", 32'({memWe[k], memRe[k]}), 32'd0);
    end

    applyStimulus(0, 1'b1, 1'b0, 32'h0000_0400, 32'h0000_2000, 0, 1'b0);
    applyStimulus(0, 1'b0, 1'b1, 32'h0000_0400, 32'h0, 1, 1'b0);
    applyStimulus(0, 1'b1, 1'b1, 32'h0000_0010, 32'hC000_0000, 0, 1'b0);
    applyStimulus(0, 1'b0, 1'b1, 32'h0000_0010, 32'h0, 0, 1'b0);
    applyStimulus(0, 1'b1, 1'b0, 32'h0000_0FFE, 32'h1122_3344, 2, 1'b0);
    applyStimulus(0, 1'b0, 1'b1, 32'hABCD_EFFE, 32'h0, 0, 1'b0);

    // Reset in the middle of a load: three read beats go out first.
    for (int b = 0; b < 3; b++) beatQ.push_back('{1'b0, 12'h400 + 12'(b), 8'h00});
    rdEn[0] = 1'b1;
    addrIn[0] = 32'h0000_0400;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    rdEn[0] = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    lastLoad[0] = 32'd0;
    lastLoad[1] = 32'd0;
    checkOutput("midResetReady", 32'(ready[0]), 32'd1);
    checkOutput("midResetRdData", rdData[0], 32'd0);
    checkOutput("midResetStrobes", 32'({memWe[0], memRe[0]}), 32'd0);
    applyStimulus(0, 1'b0, 1'b1, 32'h0000_0400, 32'h0, 1, 1'b0);

    applyStimulus(1, 1'b1, 1'b0, 32'h0000_0400, 32'h0000_2000, 1, 1'b0);
    applyStimulus(1, 1'b0, 1'b1, 32'h0000_0400, 32'h0, 0, 1'b1);
    applyStimulus(1, 1'b1, 1'b0, 32'h0000_0FFD, 32'hDEAD_BEEF, 0, 1'b1);
    applyStimulus(1, 1'b0, 1'b1, 32'h0000_0FFD, 32'h0, 0, 1'b0);

    lastWrAddr = 32'h0000_0400;
    for (int k = 0; k < 2; k++) begin
      for (int n = 0; n < 25; n++) begin
        op = $urandom_range(0, 3);
        a = $urandom;
        if ($urandom_range(0, 3) == 0) a[11:0] = 12'hFFC + 12'($urandom_range(0, 3));
        if (op != 0 && op != 2 && $urandom_range(0, 1) == 1) a = lastWrAddr;
        if (op == 0 || op == 2) lastWrAddr = a;
        applyStimulus(k, (op == 0 || op == 2), (op != 0), a, $urandom,
                      $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      end
    end

    repeat (8) @(posedge clk);
    #1;
    checkOutput("beatQueueDrained", 32'(beatQ.size()), 32'd0);
    checkOutput("doneQueueDrained", 32'(doneQ.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
